// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared state encodings, character constants and address-width
//            helpers for the UART command responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle   = 3'd0;
    localparam state_t c_st_scan   = 3'd1;
    localparam state_t c_st_decode = 3'd2;
    localparam state_t c_st_copy   = 3'd3;
    localparam state_t c_st_cr     = 3'd4;
    localparam state_t c_st_lf     = 3'd5;
    localparam state_t c_st_done   = 3'd6;

    localparam logic [7:0] c_cr          = 8'h0D;
    localparam logic [7:0] c_lf          = 8'h0A;
    localparam logic [7:0] c_qmark       = 8'h3F;
    localparam logic [7:0] c_cmd_upper   = 8'h75;
    localparam logic [7:0] c_cmd_reverse = 8'h72;

    // Number of bits needed to represent value (0 for 0).
    function automatic int log2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits = bits + 1;
            v    = v >> 1;
        end
        return bits;
    endfunction

    function automatic int calc_aw(input int depth);
        return log2(depth - 1) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_case_xform.sv
// ============================================================================
// Module   : uart_case_xform
// Purpose  : Combinational byte transform; folds 'a'..'z' to upper case when
//            enabled, otherwise passes the byte through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_case_xform (
    input  logic [7:0] i_byte,
    input  logic       i_upper_en,
    output logic [7:0] o_byte
);

    localparam logic [7:0] c_lower_a  = 8'h61;
    localparam logic [7:0] c_lower_z  = 8'h7A;
    localparam logic [7:0] c_case_gap = 8'h20;

    always_comb begin
        o_byte = i_byte;
        if (i_upper_en && (i_byte >= c_lower_a) && (i_byte <= c_lower_z)) begin
            o_byte = i_byte - c_case_gap;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
// ============================================================================
// Module   : uart_cmd_responder
// Purpose  : Reads a received line from the shared line buffer, decodes a
//            one-character command and writes the response string back.
//            Optional macro UART_CMD_REVERSE_EN enables the 'r' command.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LEN        = 256,
    parameter int RXSTR_BASE = 0,
    parameter int TXSTR_BASE = 128,
    parameter int AW         = calc_aw(LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             msg_valid,
    output logic [AW-1:0]    msg_len,
    output logic [AW-1:0]    addr,
    output logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] dout,
    output logic             we
);

    localparam logic [AW-1:0] c_one     = AW'(1);
    localparam logic [AW-1:0] c_rx_base = AW'(RXSTR_BASE);
    localparam logic [AW-1:0] c_tx_base = AW'(TXSTR_BASE);
    localparam logic [AW-1:0] c_cap     = AW'(TXSTR_BASE - RXSTR_BASE);
    localparam logic [AW-1:0] c_cap_m1  = AW'(TXSTR_BASE - RXSTR_BASE - 1);
    localparam logic [AW-1:0] c_pmax    = AW'(LEN - TXSTR_BASE - 3);

    state_t        r_state, w_state_nxt;
    logic          r_cv_d;
    logic          r_phase, w_phase_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [AW-1:0] r_n, w_n_nxt;
    logic [AW-1:0] r_p, w_p_nxt;
    logic [AW-1:0] r_wcnt, w_wcnt_nxt;
    logic [AW-1:0] r_msg_len, w_msg_len_nxt;
    logic [7:0]    r_cmd, w_cmd_nxt;
    logic          r_upper, w_upper_nxt;
`ifdef UART_CMD_REVERSE_EN
    logic          r_rev, w_rev_nxt;
`endif

    logic             w_trigger;
    logic [AW-1:0]    w_n_m1;
    logic [AW-1:0]    w_p_calc;
    logic [7:0]       w_xf_out;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_din;
    logic             w_we;
    logic             w_msg_valid;
    logic             w_is_term;

    assign w_trigger = ~cmd_valid & r_cv_d;
    assign w_is_term = (dout[7:0] == c_cr) || (dout[7:0] == c_lf);
    assign w_n_m1    = r_n - c_one;
    assign w_p_calc  = (w_n_m1 > c_pmax) ? c_pmax : w_n_m1;

    uart_case_xform u_xform (
        .i_byte     (dout[7:0]),
        .i_upper_en (r_upper),
        .o_byte     (w_xf_out)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_idx_nxt     = r_idx;
        w_n_nxt       = r_n;
        w_p_nxt       = r_p;
        w_wcnt_nxt    = r_wcnt;
        w_msg_len_nxt = r_msg_len;
        w_cmd_nxt     = r_cmd;
        w_upper_nxt   = r_upper;
`ifdef UART_CMD_REVERSE_EN
        w_rev_nxt     = r_rev;
`endif
        w_addr        = '0;
        w_din         = '0;
        w_we          = 1'b0;
        w_msg_valid   = 1'b0;

        case (r_state)
            c_st_idle: begin
                if (w_trigger) begin
                    w_state_nxt = c_st_scan;
                    w_idx_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
            end
            c_st_scan: begin
                if (!r_phase) begin
                    w_addr      = c_rx_base + r_idx;
                    w_phase_nxt = 1'b1;
                end else begin
                    w_phase_nxt = 1'b0;
                    if (r_idx == '0) w_cmd_nxt = dout[7:0];
                    if (w_is_term) begin
                        w_n_nxt     = r_idx;
                        w_state_nxt = c_st_decode;
                    end else if (r_idx == c_cap_m1) begin
                        w_n_nxt     = c_cap;
                        w_state_nxt = c_st_decode;
                    end else begin
                        w_idx_nxt = r_idx + c_one;
                    end
                end
            end
            c_st_decode: begin
                w_wcnt_nxt  = '0;
                w_idx_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_p_nxt     = w_p_calc;
                if (r_n == '0) begin
                    w_state_nxt = c_st_cr;
                end else if (r_cmd == c_cmd_upper) begin
                    w_upper_nxt = 1'b1;
`ifdef UART_CMD_REVERSE_EN
                    w_rev_nxt   = 1'b0;
`endif
                    w_state_nxt = (w_p_calc == '0) ? c_st_cr : c_st_copy;
`ifdef UART_CMD_REVERSE_EN
                end else if (r_cmd == c_cmd_reverse) begin
                    w_upper_nxt = 1'b0;
                    w_rev_nxt   = 1'b1;
                    w_state_nxt = (w_p_calc == '0) ? c_st_cr : c_st_copy;
`endif
                end else begin
                    // Unknown command: the '?' goes out in this same cycle
                    w_addr      = c_tx_base;
                    w_din       = WIDTH'(c_qmark);
                    w_we        = 1'b1;
                    w_wcnt_nxt  = c_one;
                    w_state_nxt = c_st_cr;
                end
            end
            c_st_copy: begin
                if (!r_phase) begin
`ifdef UART_CMD_REVERSE_EN
                    w_addr = r_rev ? (c_rx_base + r_n - c_one - r_idx)
                                   : (c_rx_base + c_one + r_idx);
`else
                    w_addr = c_rx_base + c_one + r_idx;
`endif
                    w_phase_nxt = 1'b1;
                end else begin
                    w_addr      = c_tx_base + r_idx;
                    w_din       = WIDTH'(w_xf_out);
                    w_we        = 1'b1;
                    w_phase_nxt = 1'b0;
                    w_wcnt_nxt  = r_wcnt + c_one;
                    w_idx_nxt   = r_idx + c_one;
                    if ((r_idx + c_one) == r_p) w_state_nxt = c_st_cr;
                end
            end
            c_st_cr: begin
                w_addr      = c_tx_base + r_wcnt;
                w_din       = WIDTH'(c_cr);
                w_we        = 1'b1;
                w_wcnt_nxt  = r_wcnt + c_one;
                w_state_nxt = c_st_lf;
            end
            c_st_lf: begin
                w_addr        = c_tx_base + r_wcnt;
                w_din         = WIDTH'(c_lf);
                w_we          = 1'b1;
                w_wcnt_nxt    = r_wcnt + c_one;
                w_msg_len_nxt = r_wcnt + c_one;
                w_state_nxt   = c_st_done;
            end
            c_st_done: begin
                w_msg_valid = 1'b1;
                w_state_nxt = c_st_idle;
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_cv_d    <= 1'b0;
            r_phase   <= 1'b0;
            r_idx     <= '0;
            r_n       <= '0;
            r_p       <= '0;
            r_wcnt    <= '0;
            r_msg_len <= '0;
            r_cmd     <= '0;
            r_upper   <= 1'b0;
`ifdef UART_CMD_REVERSE_EN
            r_rev     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cv_d    <= cmd_valid;
            r_phase   <= w_phase_nxt;
            r_idx     <= w_idx_nxt;
            r_n       <= w_n_nxt;
            r_p       <= w_p_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_msg_len <= w_msg_len_nxt;
            r_cmd     <= w_cmd_nxt;
            r_upper   <= w_upper_nxt;
`ifdef UART_CMD_REVERSE_EN
            r_rev     <= w_rev_nxt;
`endif
        end
    end

    // Reset must suppress a write or completion pulse in the cycle it is seen
    assign we        = w_we & ~rst;
    assign msg_valid = w_msg_valid & ~rst;
    assign addr      = w_addr;
    assign din       = w_din;
    assign msg_len   = r_msg_len;

endmodule

`default_nettype wire
